popcount_accumulator: RTL and testbench



---
 rtl/popcount_pkg.sv | 47 ++++
 rtl/popcount_accumulator_ones_count4.sv | 19 +
 rtl/popcount_accumulator.sv | 157 +++++++++++++++
 tb/tb_popcount_accumulator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_pkg
// Description : Shared types and constant helpers for the popcount
//               accumulator: state encoding, clog2, per-word count width
//               derivation and accumulator saturation value.
// Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    // Frame state: accumulating words, or holding a finished result
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time width derivation
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width needed to hold a count of 0..width set bits
    function automatic int cnt_width(input int width);
        return clog2(width) + 1;
    endfunction

    // All-ones value of an acc_w-bit accumulator (acc_w <= 64)
    function automatic logic [63:0] acc_max(input int acc_w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < acc_w) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_accumulator_ones_count4.sv
`default_nettype none
// ============================================================================
// Module      : ones_count4
// Description : Combinational ones counter for a 4-bit nibble (0..4).
// Revision    : 1.0 - initial release
// ============================================================================
module ones_count4 (
    input  logic [3:0] i_nibble,
    output logic [2:0] o_count
);

    // Plain adder tree; each bit zero-extended to the 3-bit result width
    always_comb begin
        o_count = {2'b00, i_nibble[0]} + {2'b00, i_nibble[1]}
                + {2'b00, i_nibble[2]} + {2'b00, i_nibble[3]};
    end

endmodule
`default_nettype wire

// File: rtl/popcount_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : popcount_accumulator
// Description : Two-stage pipelined ones counter for a WIDTH-bit word stream.
//               Per-word counts are accumulated (saturating) over a frame
//               closed by InLast; each frame total is presented on a held
//               valid/ready output.
//               Optional macro POPCOUNT_WORDS_EN adds OutWords, the number
//               of words in the frame (saturating at 65535).
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_accumulator
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int ACC_W = 16,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    input  logic             InLast,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [ACC_W-1:0] OutCount,
    output logic             OutSat,
    output logic [CNT_W-1:0] WordCount
`ifdef POPCOUNT_WORDS_EN
    ,
    output logic [15:0]      OutWords
`endif
);

    localparam int                c_GROUPS       = WIDTH / 4;
    localparam int                c_SUM_W        = ACC_W + 1;
    localparam logic [63:0]       c_ACC_MAX_WIDE = acc_max(ACC_W);
    localparam logic [ACC_W-1:0]  c_ACC_MAX      = c_ACC_MAX_WIDE[ACC_W-1:0];

    // Stage-1 registers
    logic                         r_s1_valid;
    logic                         r_s1_last;
    logic [c_GROUPS-1:0][2:0]     r_s1_groups;

    // Frame state
    state_t                       r_state;
    logic [ACC_W-1:0]             r_acc;
    logic                         r_sat;

    // Combinational helpers
    logic [c_GROUPS-1:0][2:0]     w_groups;
    logic                         w_stall;
    logic                         w_s2_fire;
    logic [CNT_W-1:0]             w_word_cnt;
    logic [c_SUM_W-1:0]           w_sum_wide;
    logic                         w_ovf;
    logic [ACC_W-1:0]             w_sum_sat;

    // Nibble counters feeding stage 1
    generate
        for (genvar g = 0; g < c_GROUPS; g++) begin : g_groups
            ones_count4 u_ones_count4 (
                .i_nibble (InData[4*g +: 4]),
                .o_count  (w_groups[g])
            );
        end
    endgenerate

    // A finished last word cannot retire while the previous result is unread
    assign w_stall   = (r_state == HOLD) && !OutReady && r_s1_valid && r_s1_last;
    assign InReady   = !w_stall;
    assign w_s2_fire = r_s1_valid && !w_stall;

    // Stage 2 arithmetic: group sum and saturating frame accumulation
    always_comb begin
        w_word_cnt = '0;
        for (int g = 0; g < c_GROUPS; g++) begin
            w_word_cnt = w_word_cnt + CNT_W'(r_s1_groups[g]);
        end
        w_sum_wide = {1'b0, r_acc} + c_SUM_W'(w_word_cnt);
        w_ovf      = w_sum_wide[ACC_W];
        w_sum_sat  = w_ovf ? c_ACC_MAX : w_sum_wide[ACC_W-1:0];
    end

    // Stage 1: capture group counts with last/valid; frozen while stalled
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_groups <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= InValid;
            r_s1_last  <= InValid && InLast;
            if (InValid) begin
                r_s1_groups <= w_groups;
            end
        end
    end

    // Stage 2 and frame FSM: accumulate, publish result, hold until taken
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            WordCount <= '0;
            OutValid  <= 1'b0;
            OutCount  <= '0;
            OutSat    <= 1'b0;
        end else begin
            if (w_s2_fire) begin
                WordCount <= w_word_cnt;
                if (r_s1_last) begin
                    OutCount <= w_sum_sat;
                    OutSat   <= r_sat || w_ovf;
                    OutValid <= 1'b1;
                    r_state  <= HOLD;
                    r_acc    <= '0;
                    r_sat    <= 1'b0;
                end else begin
                    r_acc <= w_sum_sat;
                    r_sat <= r_sat || w_ovf;
                end
            end
            // Result consumed with no new one arriving on the same edge
            if ((r_state == HOLD) && OutReady && !(w_s2_fire && r_s1_last)) begin
                OutValid <= 1'b0;
                r_state  <= ACCUM;
            end
        end
    end

`ifdef POPCOUNT_WORDS_EN
    logic [15:0] r_words;
    logic [15:0] w_words_inc;

    assign w_words_inc = (r_words == 16'hFFFF) ? r_words : (r_words + 16'd1);

    // Per-frame word counter, published alongside the ones total
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_words  <= '0;
            OutWords <= '0;
        end else if (w_s2_fire) begin
            if (r_s1_last) begin
                OutWords <= w_words_inc;
                r_words  <= '0;
            end else begin
                r_words <= w_words_inc;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_popcount_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_accumulator
// Description : Scoreboard bench for popcount_accumulator. Stimulus pushes
//               hand-computed frame results; monitors pop and compare on
//               every output handshake. A second instance uses ACC_W=5 for
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_accumulator;

    typedef struct {
        int count;
        int sat;
        int words;
    } exp_t;

    logic        Clock = 1'b0;
    logic        r_resetn;

    // Main instance (WIDTH=16, ACC_W=16)
    logic        r_in_valid, r_in_last, r_out_ready;
    logic [15:0] r_in_data;
    logic        w_in_ready, w_out_valid, w_out_sat;
    logic [15:0] w_out_count;
    logic [4:0]  w_word_count;

    // Saturation instance (WIDTH=16, ACC_W=5)
    logic        r_s_in_valid, r_s_in_last, r_s_out_ready;
    logic [15:0] r_s_in_data;
    logic        w_s_in_ready, w_s_out_valid, w_s_out_sat;
    logic [4:0]  w_s_out_count;
    logic [4:0]  w_s_word_count;

`ifdef POPCOUNT_WORDS_EN
    logic [15:0] w_out_words;
    logic [15:0] w_s_out_words;
`endif

    exp_t exp_q[$];
    exp_t sexp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 Clock = ~Clock;

    popcount_accumulator #(.WIDTH(16), .ACC_W(16)) dut (
        .Clock     (Clock),
        .Resetn    (r_resetn),
        .InValid   (r_in_valid),
        .InReady   (w_in_ready),
        .InData    (r_in_data),
        .InLast    (r_in_last),
        .OutValid  (w_out_valid),
        .OutReady  (r_out_ready),
        .OutCount  (w_out_count),
        .OutSat    (w_out_sat),
        .WordCount (w_word_count)
`ifdef POPCOUNT_WORDS_EN
        ,
        .OutWords  (w_out_words)
`endif
    );

    popcount_accumulator #(.WIDTH(16), .ACC_W(5)) dut_sat (
        .Clock     (Clock),
        .Resetn    (r_resetn),
        .InValid   (r_s_in_valid),
        .InReady   (w_s_in_ready),
        .InData    (r_s_in_data),
        .InLast    (r_s_in_last),
        .OutValid  (w_s_out_valid),
        .OutReady  (r_s_out_ready),
        .OutCount  (w_s_out_count),
        .OutSat    (w_s_out_sat),
        .WordCount (w_s_word_count)
`ifdef POPCOUNT_WORDS_EN
        ,
        .OutWords  (w_s_out_words)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge
    task automatic sync();
        @(posedge Clock);
        #1;
    endtask

    // Offer one word to the main instance; returns just after acceptance
    task automatic send(input logic [15:0] d, input logic l);
        int guard;
        guard      = 0;
        r_in_valid = 1'b1;
        r_in_data  = d;
        r_in_last  = l;
        @(negedge Clock);
        while (!w_in_ready && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL send_timeout: InReady stayed %0d, expected 1", w_in_ready);
        end
        sync();
        r_in_valid = 1'b0;
        r_in_last  = 1'b0;
    endtask

    task automatic send_sat(input logic [15:0] d, input logic l);
        int guard;
        guard        = 0;
        r_s_in_valid = 1'b1;
        r_s_in_data  = d;
        r_s_in_last  = l;
        @(negedge Clock);
        while (!w_s_in_ready && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL send_sat_timeout: InReady stayed %0d, expected 1", w_s_in_ready);
        end
        sync();
        r_s_in_valid = 1'b0;
        r_s_in_last  = 1'b0;
    endtask

    function automatic exp_t mk(input int c, input int s, input int w);
        exp_t e;
        e.count = c;
        e.sat   = s;
        e.words = w;
        return e;
    endfunction

    // Main-instance monitor: compare every result handshake with the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (r_resetn && w_out_valid && r_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL main_unexpected: got result %0d, expected no result", w_out_count);
                end else begin
                    e = exp_q.pop_front();
                    check("main_count", 64'(w_out_count), 64'(e.count));
                    check("main_sat", 64'(w_out_sat), 64'(e.sat));
`ifdef POPCOUNT_WORDS_EN
                    check("main_words", 64'(w_out_words), 64'(e.words));
`endif
                end
            end
        end
    end

    // Saturation-instance monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (r_resetn && w_s_out_valid && r_s_out_ready) begin
                if (sexp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sat_unexpected: got result %0d, expected no result", w_s_out_count);
                end else begin
                    e = sexp_q.pop_front();
                    check("sat_count", 64'(w_s_out_count), 64'(e.count));
                    check("sat_flag", 64'(w_s_out_sat), 64'(e.sat));
`ifdef POPCOUNT_WORDS_EN
                    check("sat_words", 64'(w_s_out_words), 64'(e.words));
`endif
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        r_resetn      = 1'b0;
        r_in_valid    = 1'b0;
        r_in_last     = 1'b0;
        r_in_data     = '0;
        r_out_ready   = 1'b1;
        r_s_in_valid  = 1'b0;
        r_s_in_last   = 1'b0;
        r_s_in_data   = '0;
        r_s_out_ready = 1'b1;

        repeat (3) sync();
        @(negedge Clock);
        check("reset_out_valid", 64'(w_out_valid), 64'd0);
        check("reset_out_count", 64'(w_out_count), 64'd0);
        check("reset_out_sat", 64'(w_out_sat), 64'd0);
        check("reset_word_count", 64'(w_word_count), 64'd0);
        sync();
        r_resetn = 1'b1;
        @(negedge Clock);
        check("reset_in_ready", 64'(w_in_ready), 64'd1);
        sync();

        // Single-word frame of all ones
        exp_q.push_back(mk(16, 0, 1));
        send(16'hFFFF, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        check("single_word_count", 64'(w_word_count), 64'd16);
        check("single_out_valid", 64'(w_out_valid), 64'd1);
        check("single_out_count", 64'(w_out_count), 64'd16);
        sync();

        // Three-word frame then a back-to-back four-word frame
        exp_q.push_back(mk(9, 0, 3));
        send(16'h0001, 1'b0);
        send(16'h00F0, 1'b0);
        send(16'h8421, 1'b1);
        exp_q.push_back(mk(40, 0, 4));
        send(16'h000F, 1'b0);
        send(16'h00FF, 1'b0);
        send(16'h0FFF, 1'b0);
        send(16'hFFFF, 1'b1);
        repeat (4) sync();

        // Backpressure: hold first result while second frame's last waits
        r_out_ready = 1'b0;
        exp_q.push_back(mk(4, 0, 1));
        send(16'h1111, 1'b1);
        exp_q.push_back(mk(17, 0, 2));
        send(16'h0101, 1'b0);
        send(16'h7FFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("stall_in_ready", 64'(w_in_ready), 64'd0);
            check("stall_out_valid", 64'(w_out_valid), 64'd1);
            check("stall_out_count", 64'(w_out_count), 64'd4);
        end
        sync();
        r_out_ready = 1'b1;
        sync();
        @(negedge Clock);
        check("release_out_valid", 64'(w_out_valid), 64'd1);
        check("release_out_count", 64'(w_out_count), 64'd17);
        repeat (3) sync();

        // Saturation on a 5-bit accumulator, then recovery
        sexp_q.push_back(mk(31, 1, 3));
        send_sat(16'hFFFF, 1'b0);
        send_sat(16'hFFFF, 1'b0);
        send_sat(16'hFFFF, 1'b1);
        sexp_q.push_back(mk(2, 0, 1));
        send_sat(16'h0003, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        check("sat_word_count", 64'(w_s_word_count), 64'd2);
        repeat (4) sync();

        // Reset mid-frame discards the partial sum
        send(16'h00FF, 1'b0);
        send(16'h0F0F, 1'b0);
        r_resetn = 1'b0;
        repeat (2) sync();
        @(negedge Clock);
        check("midreset_out_valid", 64'(w_out_valid), 64'd0);
        check("midreset_word_count", 64'(w_word_count), 64'd0);
        sync();
        r_resetn = 1'b1;
        sync();
        exp_q.push_back(mk(4, 0, 1));
        send(16'h000F, 1'b1);

        repeat (10) sync();
        check("main_queue_drained", 64'(exp_q.size()), 64'd0);
        check("sat_queue_drained", 64'(sexp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
